// File: rtl/cw_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cw_capture_ctrl
// Trigger and capture controller for a circular trace RAM. The probed bus is
// written continuously once a capture is armed. A pre-trigger window is filled
// first. Then the block waits for a trigger built from per-channel compares.
// After the trigger, post_len further samples are written and the block stops.
//
// Ports
//   trig_clk   : sole clock, rising edge
//   jrstn      : asynchronous active-low reset
//   arm        : level-sampled capture start (honoured in IDLE/DONE only)
//   abort      : return to IDLE at the next edge (wins over arm)
//   trig_mode  : 0 = AND of enabled channel matches, 1 = OR
//   ch_en      : per-channel enable
//   cmp_op     : per-channel operator, 2 bits each
//                (00 eq, 01 ne, 10 masked rising edge, 11 always)
//   cmp_val    : per-channel compare value, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   cmp_mask   : per-channel compare mask, same packing
//   post_len   : samples written after the trigger sample
//   bus_din    : probed signals, same packing
//   wt_ce      : trace RAM chip enable
//   wt_en      : trace RAM write strobe
//   wt_addr    : trace RAM write address
//   trig_addr  : address of the trigger sample
//   state      : IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4
//   done       : high while in DONE
// -----------------------------------------------------------------------------
module cw_capture_ctrl #(
    parameter int BUS_NUM    = 4,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          trig_clk,
    input  logic                          jrstn,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          trig_mode,
    input  logic [BUS_NUM-1:0]            ch_en,
    input  logic [2*BUS_NUM-1:0]          cmp_op,
    input  logic [BUS_NUM*BUS_WIDTH-1:0]  cmp_val,
    input  logic [BUS_NUM*BUS_WIDTH-1:0]  cmp_mask,
    input  logic [ADDR_WIDTH-1:0]         post_len,
    input  logic [BUS_NUM*BUS_WIDTH-1:0]  bus_din,
    output logic                          wt_ce,
    output logic                          wt_en,
    output logic [ADDR_WIDTH-1:0]         wt_addr,
    output logic [ADDR_WIDTH-1:0]         trig_addr,
    output logic [2:0]                    state,
    output logic                          done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Per-channel compare of the registered sample against value/mask.
    function automatic logic chan_match(
        input logic [1:0]           op,
        input logic [BUS_WIDTH-1:0] d,
        input logic [BUS_WIDTH-1:0] d_prev,
        input logic [BUS_WIDTH-1:0] v,
        input logic [BUS_WIDTH-1:0] m
    );
        logic r;
        case (op)
            2'b00:   r = ((d & m) == (v & m));
            2'b01:   r = ((d & m) != (v & m));
            2'b10:   r = |(m & d & ~d_prev);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    state_t                         state_r, state_nxt_s;
    logic [BUS_NUM*BUS_WIDTH-1:0]   din_q_r, din_q2_r;
    logic [ADDR_WIDTH-1:0]          addr_r, addr_nxt_s;
    logic [ADDR_WIDTH-1:0]          trig_r, trig_nxt_s;
    logic [ADDR_WIDTH-1:0]          cnt_r, cnt_nxt_s;
    logic                           wt_ce_r, wt_en_r, done_r;
    logic [BUS_NUM-1:0]             match_s;
    logic                           hit_s;
    logic [ADDR_WIDTH-1:0]          pre_depth_s;

    genvar gi;
    generate
        for (gi = 0; gi < BUS_NUM; gi++) begin : g_match
            assign match_s[gi] = chan_match(cmp_op[2*gi +: 2],
                                            din_q_r[gi*BUS_WIDTH +: BUS_WIDTH],
                                            din_q2_r[gi*BUS_WIDTH +: BUS_WIDTH],
                                            cmp_val[gi*BUS_WIDTH +: BUS_WIDTH],
                                            cmp_mask[gi*BUS_WIDTH +: BUS_WIDTH]);
        end
    endgenerate

    // Disabled channels are neutral in both modes; no enabled channel means no hit.
    assign hit_s = (|ch_en) &
                   (trig_mode ? (|(match_s & ch_en)) : (&(match_s | ~ch_en)));

    // DEPTH-1-post_len in ADDR_WIDTH bits is simply the bitwise inverse.
    assign pre_depth_s = ~post_len;

    // Probe pipeline: din_q feeds the compares, din_q2 gives the previous sample for edge detect.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            din_q_r  <= {(BUS_NUM*BUS_WIDTH){1'b0}};
            din_q2_r <= {(BUS_NUM*BUS_WIDTH){1'b0}};
        end else begin
            din_q_r  <= bus_din;
            din_q2_r <= din_q_r;
        end
    end

    // Next-state and datapath update; cnt_r counts writes within PRE and POST.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        trig_nxt_s  = trig_r;
        cnt_nxt_s   = cnt_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        addr_nxt_s  = ADDR_ZERO;
                        cnt_nxt_s   = ADDR_ZERO;
                        state_nxt_s = (pre_depth_s != ADDR_ZERO) ? ST_PRE : ST_ARMED;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_PRE: begin
                    addr_nxt_s = addr_r + ADDR_ONE;
                    if (cnt_r == pre_depth_s - ADDR_ONE) begin
                        cnt_nxt_s   = ADDR_ZERO;
                        state_nxt_s = ST_ARMED;
                    end else begin
                        cnt_nxt_s   = cnt_r + ADDR_ONE;
                    end
                end
                ST_ARMED: begin
                    addr_nxt_s = addr_r + ADDR_ONE;
                    if (hit_s) begin
                        trig_nxt_s  = addr_r;
                        cnt_nxt_s   = ADDR_ZERO;
                        state_nxt_s = (post_len != ADDR_ZERO) ? ST_POST : ST_DONE;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_POST: begin
                    addr_nxt_s = addr_r + ADDR_ONE;
                    if (cnt_r == post_len - ADDR_ONE) begin
                        cnt_nxt_s   = ADDR_ZERO;
                        state_nxt_s = ST_DONE;
                    end else begin
                        cnt_nxt_s   = cnt_r + ADDR_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, address, counter and registered RAM controls.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            state_r <= ST_IDLE;
            addr_r  <= ADDR_ZERO;
            trig_r  <= ADDR_ZERO;
            cnt_r   <= ADDR_ZERO;
            wt_ce_r <= 1'b0;
            wt_en_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            trig_r  <= trig_nxt_s;
            cnt_r   <= cnt_nxt_s;
            wt_ce_r <= (state_nxt_s != ST_IDLE);
            wt_en_r <= (state_nxt_s == ST_PRE) || (state_nxt_s == ST_ARMED) ||
                       (state_nxt_s == ST_POST);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign state     = state_r;
    assign wt_addr   = addr_r;
    assign trig_addr = trig_r;
    assign wt_ce     = wt_ce_r;
    assign wt_en     = wt_en_r;
    assign done      = done_r;

endmodule
